// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: branch resolve, word data memory, MEM/WB register, sticky fault
module mem_stage #(
    parameter int ADDR_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_branch_pc,
    input  logic [31:0] i_result,
    input  logic        i_zero,
    input  logic [31:0] i_read_data2,
    input  logic [4:0]  i_write_reg,
    input  logic [1:0]  i_WB_control,
    input  logic [2:0]  i_MEM_control,
    output logic        o_pc_src,
    output logic [31:0] o_branch_pc,
    output logic [31:0] o_read_data,
    output logic [31:0] o_alu_result,
    output logic [4:0]  o_write_reg,
    output logic [1:0]  o_WB_control,
    output logic        o_mem_fault,
    output logic [31:0] o_fault_addr
);

    typedef enum logic {
        S_OK      = 1'b0,
        S_FAULTED = 1'b1
    } fault_state_t;

    logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
    logic [31:0]       r_read_data;
    logic [31:0]       r_alu_result;
    logic [4:0]        r_write_reg;
    logic [1:0]        r_wb_control;
    logic [31:0]       r_fault_addr;
    fault_state_t      r_state;
    fault_state_t      w_next_state;
    logic              w_capture;
    logic [ADDR_W-1:0] w_index;
    logic              w_legal;
    logic              w_store;
    logic              w_load;
    logic              w_fault;

    // Range check on the full upper address so 0x400 can never alias word 0.
    assign w_index = i_result[ADDR_W+1:2];
    assign w_legal = (i_result[1:0] == 2'b00) && (i_result[31:ADDR_W+2] == '0);
    assign w_store = i_MEM_control[0];
    assign w_load  = i_MEM_control[1] & ~i_MEM_control[0];
    assign w_fault = (w_store | w_load) & ~w_legal;

    assign o_pc_src    = i_MEM_control[2] & i_zero;
    assign o_branch_pc = i_branch_pc;

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_store && w_legal) begin
            r_mem[w_index] <= i_read_data2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_write_reg  <= '0;
            r_wb_control <= '0;
        end else begin
            r_read_data  <= (w_load && w_legal) ? r_mem[w_index] : 32'h0;
            r_alu_result <= i_result;
            r_write_reg  <= i_write_reg;
            r_wb_control <= {i_WB_control[1] & ~(w_load & ~w_legal), i_WB_control[0]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_OK;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == S_OK && w_fault) begin
            w_next_state = S_FAULTED;
        end
    end

    always_comb begin
        o_mem_fault = (r_state == S_FAULTED);
        w_capture   = (r_state == S_OK) && w_fault;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fault_addr <= '0;
        end else if (w_capture) begin
            r_fault_addr <= i_result;
        end
    end

    assign o_read_data  = r_read_data;
    assign o_alu_result = r_alu_result;
    assign o_write_reg  = r_write_reg;
    assign o_WB_control = r_wb_control;
    assign o_fault_addr = r_fault_addr;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a behavioural model
module tb_mem_stage;

    localparam int AW = 8;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_branch_pc = '0;
    logic [31:0] i_result = '0;
    logic        i_zero = 1'b0;
    logic [31:0] i_read_data2 = '0;
    logic [4:0]  i_write_reg = '0;
    logic [1:0]  i_WB_control = '0;
    logic [2:0]  i_MEM_control = '0;
    logic        o_pc_src;
    logic [31:0] o_branch_pc;
    logic [31:0] o_read_data;
    logic [31:0] o_alu_result;
    logic [4:0]  o_write_reg;
    logic [1:0]  o_WB_control;
    logic        o_mem_fault;
    logic [31:0] o_fault_addr;

    int checks = 0;
    int failures = 0;

    // Reference state: sparse memory of written words, plus sticky fault record.
    logic [31:0] m_mem [int];
    logic        m_fault = 1'b0;
    logic [31:0] m_faddr = '0;

    mem_stage #(.ADDR_W(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_branch_pc(i_branch_pc), .i_result(i_result),
        .i_zero(i_zero), .i_read_data2(i_read_data2), .i_write_reg(i_write_reg),
        .i_WB_control(i_WB_control), .i_MEM_control(i_MEM_control), .o_pc_src(o_pc_src),
        .o_branch_pc(o_branch_pc), .o_read_data(o_read_data), .o_alu_result(o_alu_result),
        .o_write_reg(o_write_reg), .o_WB_control(o_WB_control), .o_mem_fault(o_mem_fault),
        .o_fault_addr(o_fault_addr)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One instruction through the stage; every output is compared with the model.
    task automatic issue(input logic [31:0] bp, input logic [31:0] res, input logic zero,
                         input logic [31:0] wd, input logic [4:0] wr, input logic [1:0] wbc,
                         input logic [2:0] memc);
        logic        legal, st, ld, flt, known;
        logic [31:0] exp_rd;
        logic [1:0]  exp_wb;
        int          idx;
        i_branch_pc = bp; i_result = res; i_zero = zero; i_read_data2 = wd;
        i_write_reg = wr; i_WB_control = wbc; i_MEM_control = memc;
        #1;
        check("pc_src", {31'b0, o_pc_src}, {31'b0, memc[2] & zero});
        check("branch_pc", o_branch_pc, bp);
        legal = (res % 4 == 0) && (res < 4 * (1 << AW));
        st    = memc[0];
        ld    = memc[1] && !memc[0];
        flt   = (st || ld) && !legal;
        idx   = int'(res / 4);
        known = 1'b1;
        exp_rd = 32'h0;
        if (ld && legal) begin
            if (m_mem.exists(idx)) exp_rd = m_mem[idx];
            else known = 1'b0;
        end
        exp_wb = (ld && !legal) ? {1'b0, wbc[0]} : wbc;
        if (st && legal) m_mem[idx] = wd;
        if (flt && !m_fault) begin
            m_fault = 1'b1;
            m_faddr = res;
        end
        @(posedge i_clk);
        #1;
        if (known) check("read_data", o_read_data, exp_rd);
        check("alu_result", o_alu_result, res);
        check("write_reg", {27'b0, o_write_reg}, {27'b0, wr});
        check("wb_control", {30'b0, o_WB_control}, {30'b0, exp_wb});
        check("mem_fault", {31'b0, o_mem_fault}, {31'b0, m_fault});
        check("fault_addr", o_fault_addr, m_faddr);
    endtask

    task automatic do_reset(input int cycles);
        i_rst = 1'b1;
        i_MEM_control = 3'b001; i_result = 32'h10; i_read_data2 = 32'hDEADBEEF;
        i_WB_control = 2'b11; i_write_reg = 5'd7;
        repeat (cycles) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        m_fault = 1'b0;
        m_faddr = '0;
        check("rst_read_data", o_read_data, 32'h0);
        check("rst_alu_result", o_alu_result, 32'h0);
        check("rst_write_reg", {27'b0, o_write_reg}, 32'h0);
        check("rst_wb_control", {30'b0, o_WB_control}, 32'h0);
        check("rst_mem_fault", {31'b0, o_mem_fault}, 32'h0);
        check("rst_fault_addr", o_fault_addr, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h400;
            1:       return $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
            2:       return $urandom();
            3:       return 32'h3FC;
            default: return $urandom_range(0, 15) * 4;
        endcase
    endfunction

    initial begin
        do_reset(2);

        // Nothing was written during reset, so 0x10 must not hold the reset-time data.
        issue(32'h0, 32'h10, 1'b0, 32'h0, 5'd1, 2'b11, 3'b010);
        check("rst_no_write", {31'b0, o_read_data == 32'hDEADBEEF}, 32'h0);

        issue(32'h0, 32'h3FC, 1'b0, 32'h12345678, 5'd0, 2'b00, 3'b001);
        issue(32'h0, 32'h3FC, 1'b0, 32'h0, 5'd9, 2'b11, 3'b010);
        check("sl_read_data", o_read_data, 32'h12345678);
        check("sl_wb", {30'b0, o_WB_control}, 32'h3);

        issue(32'h0, 32'h100, 1'b0, 32'hAAAA5555, 5'd0, 2'b00, 3'b001);
        issue(32'h0, 32'h102, 1'b0, 32'h11111111, 5'd0, 2'b00, 3'b001);
        check("mis_fault", {31'b0, o_mem_fault}, 32'h1);
        check("mis_faddr", o_fault_addr, 32'h102);
        issue(32'h0, 32'h100, 1'b0, 32'h0, 5'd3, 2'b11, 3'b010);
        check("mis_read_data", o_read_data, 32'hAAAA5555);

        do_reset(1);
        issue(32'h0, 32'h400, 1'b0, 32'h0, 5'd4, 2'b11, 3'b010);
        check("oor_read_data", o_read_data, 32'h0);
        check("oor_wb", {30'b0, o_WB_control}, 32'h1);
        issue(32'h0, 32'h801, 1'b0, 32'h5, 5'd0, 2'b00, 3'b001);
        check("oor_faddr", o_fault_addr, 32'h400);
        issue(32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 3'b000);
        check("oor_sticky", {31'b0, o_mem_fault}, 32'h1);
        issue(32'h0, 32'h0, 1'b0, 32'h0, 5'd2, 2'b11, 3'b010);
        check("oor_word0_intact", {31'b0, o_read_data == 32'h5}, 32'h0);

        issue(32'h00400020, 32'h0, 1'b1, 32'h0, 5'd0, 2'b00, 3'b100);
        issue(32'h00400020, 32'h0, 1'b0, 32'h0, 5'd0, 2'b00, 3'b100);
        issue(32'h00400020, 32'h0, 1'b1, 32'h0, 5'd0, 2'b00, 3'b000);

        do_reset(1);
        issue(32'h0, 32'hFFFF0000, 1'b0, 32'h0, 5'd31, 2'b10, 3'b000);
        check("rtype_fault", {31'b0, o_mem_fault}, 32'h0);
        check("rtype_wb", {30'b0, o_WB_control}, 32'h2);

        // Memory survives a mid-stream reset.
        issue(32'h0, 32'h20, 1'b0, 32'hCAFEF00D, 5'd0, 2'b00, 3'b001);
        do_reset(1);
        issue(32'h0, 32'h20, 1'b0, 32'h0, 5'd6, 2'b11, 3'b010);
        check("rst_keeps_mem", o_read_data, 32'hCAFEF00D);

        for (int blk = 0; blk < 4; blk++) begin
            do_reset($urandom_range(1, 2));
            for (int n = 0; n < 150; n++) begin
                issue($urandom(), rand_addr(), 1'($urandom_range(0, 1)), $urandom(),
                      5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipelined CPU. It consumes the EX/MEM pipeline register outputs, resolves the branch decision for the fetch stage, and performs loads and stores against an internal word-addressed data memory. It registers everything the write-back stage needs into the MEM/WB pipeline register. It also detects illegal data accesses and records the first one in a sticky fault flag.

## Interface
- ADDR_W, 8: log2 of data-memory depth in 32-bit words (256 words).
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  synchronous, active-high reset.
- i_branch_pc  in  32  branch target from EX/MEM.
- i_result  in  32  ALU result from EX/MEM (byte address for loads/stores).
- i_zero  in  1  ALU zero flag from EX/MEM.
- i_read_data2  in  32  store data from EX/MEM.
- i_write_reg  in  5  destination register from EX/MEM.
- i_WB_control  in  2  [1]=RegWrite, [0]=MemtoReg; passed through.
- i_MEM_control  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite.
- o_pc_src  out  1  combinational: i_MEM_control[2] & i_zero.
- o_branch_pc  out  32  combinational copy of i_branch_pc.
- o_read_data  out  32  MEM/WB: loaded word.
- o_alu_result  out  32  MEM/WB: copy of i_result.
- o_write_reg  out  5  MEM/WB: copy of i_write_reg.
- o_WB_control  out  2  MEM/WB: copy of i_WB_control, RegWrite forced 0 on a faulting load.
- o_mem_fault  out  1  sticky fault flag.
- o_fault_addr  out  32  address of the first faulting access.

## Operation
- **Data memory**
  - 2^ADDR_W words of 32 bits.
  - Word index = i_result[ADDR_W+1:2].
  - Reads are combinational from the array. Writes are synchronous.
  - Contents are not cleared by reset. Contents are undefined until written.
- **Legal access**: i_result[1:0]==2'b00 and i_result[31:ADDR_W+2]==0. Any other address is illegal.
- **Store** (MemWrite=1)
  - Legal address: mem[index] <= i_read_data2 at the clock edge.
  - Illegal address: the write is suppressed and a fault is raised.
- **Load** (MemRead=1)
  - Legal address: mem[index] is captured into o_read_data.
  - Illegal address: o_read_data <= 0, RegWrite is forced 0 in the captured o_WB_control, and a fault is raised.
- **No access**: MemRead=0 and MemWrite=0 never fault. o_read_data <= 0.
- **Both set**: MemRead=1 and MemWrite=1 together is treated as a store only. o_read_data <= 0.
- **Fault tracking**
  - Two states: OK and FAULTED.
  - OK -> FAULTED on any fault. o_fault_addr <= i_result in the same cycle.
  - In FAULTED, later faults do not update o_fault_addr.
  - Only i_rst returns the block to OK.
  - Faults never stall or block the pipeline.
- **Branch resolution**: o_pc_src and o_branch_pc are purely combinational and are not registered here.
- **Reset**: while i_rst=1, no memory write occurs, even if MemWrite=1.

## Timing
- **MEM/WB register latency**: inputs presented in cycle N appear on o_read_data, o_alu_result, o_write_reg and o_WB_control after the rising edge ending cycle N.
- **Store visibility**: a store in cycle N is visible to a load of the same word in cycle N+1. Loaded data appears at the output in N+2.
- **Same-cycle read/write**: not reachable, because one instruction occupies the stage per cycle.
- **o_pc_src**: zero-cycle latency from i_MEM_control/i_zero.
- **Reset values**, applied at the first rising edge with i_rst=1:
  - o_read_data = 0, o_alu_result = 0, o_write_reg = 0, o_WB_control = 2'b00.
  - o_mem_fault = 0, o_fault_addr = 0, fault state = OK.
- **Reset mid-stream**: the in-flight instruction is discarded and the MEM/WB contents are zeroed. Memory contents are kept.
- **Fault flag timing**: o_mem_fault rises one edge after the faulting cycle and stays high until reset.
- **Address range**: the top legal byte address is 4*2^ADDR_W-4, i.e. 0x3FC for the default ADDR_W=8. Byte address 0x400 is out of range and is never folded back to index 0.

## Test plan
- **Reset**: hold i_rst=1 for 2 cycles with MemWrite=1, result=0x10, data=0xDEADBEEF. Required: all outputs 0, no fault. A later load of 0x10 does not return 0xDEADBEEF unless it was written after reset.
- **Store then load**:
  - Cycle 1: store 0x12345678 to 0x3FC.
  - Cycle 2: load 0x3FC with WB_control=2'b11, write_reg=5'd9.
  - Cycle 3: o_read_data=0x12345678, o_write_reg=9, o_WB_control=2'b11, o_alu_result=0x3FC.
- **Misaligned store**: store to 0x102, then load 0x100 (previously written 0xAAAA5555). Required:
  - o_read_data=0xAAAA5555.
  - o_mem_fault=1 from the edge after the store.
  - o_fault_addr=0x102.
- **Out-of-range load followed by a second fault**: load 0x400 with WB_control=2'b11, then store to 0x801. Required:
  - o_read_data=0 and o_WB_control=2'b01 after the load.
  - o_fault_addr stays 0x400 after the store.
  - o_mem_fault stays 1 until the next i_rst.
- **Branch decision**: set MEM_control=3'b100 and vary i_zero. Required:
  - i_zero=1: o_pc_src=1 in the same cycle, o_branch_pc equals i_branch_pc (e.g. 0x00400020).
  - i_zero=0: o_pc_src=0.
  - MEM_control=3'b000 with i_zero=1: o_pc_src=0.
- **R-type passthrough**: MEM_control=0, result=0xFFFF0000, WB_control=2'b10, write_reg=31. Required next cycle: o_alu_result=0xFFFF0000, o_read_data=0, o_write_reg=31, o_WB_control=2'b10, no fault, even though the address is out of range.
